// File: rtl/eth_header_tx.sv
// eth_header_tx: GMII transmit framer.
// Sends preamble, SFD, destination MAC, source MAC and EtherType, then
// forwards payload bytes over valid/ready and holds the inter-frame gap.
// No FCS is generated here. GMII outputs are registered.
// Optional feature macro: ETH_TX_PAD_EN (pads short payloads with 0x00 up to
// MIN_PAYLOAD bytes).
module eth_header_tx #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12,
    parameter int MAX_PAYLOAD  = 1500,
    parameter int MIN_PAYLOAD  = 46
) (
    input  logic        mac_gmii_tx_clk,
    input  logic        mac_gmii_tx_rstn,
    input  logic        tx_start,
    input  logic        tx_eth_type_arp,
    input  logic [47:0] mac_d_addr,
    input  logic [47:0] mac_s_addr,
    input  logic [7:0]  payload_data,
    input  logic        payload_valid,
    input  logic        payload_last,
    output logic        payload_ready,
    output logic        tx_busy,
    output logic        tx_abort,
    output logic [7:0]  mac_gmii_txd,
    output logic        mac_gmii_tx_en,
    output logic        mac_gmii_tx_er
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_MAC_DST,
        ST_MAC_SRC,
        ST_ETH_TYPE,
        ST_PAYLOAD,
        ST_IFG
`ifdef ETH_TX_PAD_EN
        , ST_PAD
`endif
    } state_t;

    // The IDLE cycle that accepts tx_start already drives the first 0x55,
    // so the PREAMBLE state covers only the remaining PREAMBLE_LEN-1 bytes.
    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN > 1 ? PREAMBLE_LEN - 2 : 0);
    localparam logic [10:0] IFG_LAST = 11'(IFG_LEN - 1);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
`ifdef ETH_TX_PAD_EN
    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
`endif

    // Reject configurations the 11-bit counter or the framing cannot honour.
    if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 7 || IFG_LEN < 1 || IFG_LEN > 15 ||
        MAX_PAYLOAD < 1 || MAX_PAYLOAD > 2047 || MIN_PAYLOAD > MAX_PAYLOAD) begin : g_bad_cfg
        $error("eth_header_tx: parameter out of legal range");
    end

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [47:0] d_addr_q, s_addr_q;
    logic        arp_q;
    logic        latch_en;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        abort_q, abort_d;

    // Byte views of the latched addresses, most significant byte first.
    logic [7:0] d_byte [8];
    logic [7:0] s_byte [8];
    for (genvar gi = 0; gi < 8; gi++) begin : g_addr_bytes
        if (gi < 6) begin : g_used
            assign d_byte[gi] = d_addr_q[47 - 8*gi -: 8];
            assign s_byte[gi] = s_addr_q[47 - 8*gi -: 8];
        end else begin : g_unused
            assign d_byte[gi] = 8'h00;
            assign s_byte[gi] = 8'h00;
        end
    end

    // The payload counter saturates the frame at MAX_PAYLOAD by withholding ready.
    assign payload_ready = (state_q == ST_PAYLOAD) && (cnt_q != MAX_CNT);
    assign tx_busy       = (state_q != ST_IDLE);

    // Next-state and next-output logic; each state decides the byte driven next cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        txd_d    = 8'h00;
        tx_en_d  = 1'b0;
        tx_er_d  = 1'b0;
        abort_d  = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    latch_en = 1'b1;
                    txd_d    = 8'h55;
                    tx_en_d  = 1'b1;
                    cnt_d    = 11'd0;
                    state_d  = (PREAMBLE_LEN > 1) ? ST_PREAMBLE : ST_SFD;
                end
            end
            ST_PREAMBLE: begin
                txd_d   = 8'h55;
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + 11'd1;
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    cnt_d   = 11'd0;
                end
            end
            ST_SFD: begin
                txd_d   = 8'hD5;
                tx_en_d = 1'b1;
                state_d = ST_MAC_DST;
                cnt_d   = 11'd0;
            end
            ST_MAC_DST: begin
                txd_d   = d_byte[cnt_q[2:0]];
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + 11'd1;
                if (cnt_q == 11'd5) begin
                    state_d = ST_MAC_SRC;
                    cnt_d   = 11'd0;
                end
            end
            ST_MAC_SRC: begin
                txd_d   = s_byte[cnt_q[2:0]];
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + 11'd1;
                if (cnt_q == 11'd5) begin
                    state_d = ST_ETH_TYPE;
                    cnt_d   = 11'd0;
                end
            end
            ST_ETH_TYPE: begin
                txd_d   = cnt_q[0] ? (arp_q ? 8'h06 : 8'h00) : 8'h08;
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + 11'd1;
                if (cnt_q == 11'd1) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = 11'd0;
                end
            end
            ST_PAYLOAD: begin
                tx_en_d = 1'b1;
                if (payload_ready && payload_valid) begin
                    txd_d = payload_data;
                    cnt_d = cnt_q + 11'd1;
                    if (payload_last) begin
                        state_d = ST_IFG;
                        cnt_d   = 11'd0;
`ifdef ETH_TX_PAD_EN
                        // Short frame: keep the running byte count for PAD.
                        if ((cnt_q + 11'd1) < MIN_CNT) begin
                            state_d = ST_PAD;
                            cnt_d   = cnt_q + 11'd1;
                        end
`endif
                    end
                end else begin
                    // Underrun or oversize: one error byte, then the gap.
                    tx_er_d = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_IFG;
                    cnt_d   = 11'd0;
                end
            end
`ifdef ETH_TX_PAD_EN
            ST_PAD: begin
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + 11'd1;
                if (cnt_q == MIN_CNT - 11'd1) begin
                    state_d = ST_IFG;
                    cnt_d   = 11'd0;
                end
            end
`endif
            ST_IFG: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 11'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 11'd0;
            end
        endcase
    end

    // State, counter and registered GMII outputs.
    always_ff @(posedge mac_gmii_tx_clk) begin
        if (!mac_gmii_tx_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 11'd0;
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            tx_er_q <= tx_er_d;
            abort_q <= abort_d;
        end
    end

    // Frame parameters captured on an accepted tx_start and held for the frame.
    always_ff @(posedge mac_gmii_tx_clk) begin
        if (!mac_gmii_tx_rstn) begin
            d_addr_q <= 48'd0;
            s_addr_q <= 48'd0;
            arp_q    <= 1'b0;
        end else if (latch_en) begin
            d_addr_q <= mac_d_addr;
            s_addr_q <= mac_s_addr;
            arp_q    <= tx_eth_type_arp;
        end
    end

    assign mac_gmii_txd   = txd_q;
    assign mac_gmii_tx_en = tx_en_q;
    assign mac_gmii_tx_er = tx_er_q;
    assign tx_abort       = abort_q;

endmodule

// File: tb/tb_eth_header_tx.sv
// Testbench for eth_header_tx: scoreboard of expected GMII bytes built from
// the frame format, checked by an independent monitor on every active byte.
module tb_eth_header_tx;

    localparam int MIN_PL = 46;
    localparam int IFG    = 12;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tx_start;
    logic        arp_in;
    logic [47:0] d_in, s_in;
    logic [7:0]  pdata;
    logic        pvalid, plast;
    logic        payload_ready, tx_busy, tx_abort;
    logic [7:0]  txd;
    logic        tx_en, tx_er;

    eth_header_tx dut (
        .mac_gmii_tx_clk  (clk),
        .mac_gmii_tx_rstn (rstn),
        .tx_start         (tx_start),
        .tx_eth_type_arp  (arp_in),
        .mac_d_addr       (d_in),
        .mac_s_addr       (s_in),
        .payload_data     (pdata),
        .payload_valid    (pvalid),
        .payload_last     (plast),
        .payload_ready    (payload_ready),
        .tx_busy          (tx_busy),
        .tx_abort         (tx_abort),
        .mac_gmii_txd     (txd),
        .mac_gmii_tx_en   (tx_en),
        .mac_gmii_tx_er   (tx_er)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];   // {tx_en, tx_abort, tx_er, txd}
    int hi_runs[$];
    int lo_runs[$];
    logic [7:0] pl_q[$];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every cycle with GMII activity must match the next expected byte.
    logic        prev_en = 1'b0;
    logic        hi_seen = 1'b0;
    int          hi_cnt = 0;
    int          lo_cnt = 0;
    always @(negedge clk) begin
        logic [10:0] got, e;
        got = {tx_en, tx_abort, tx_er, txd};
        if (tx_en === 1'b1 || tx_er === 1'b1 || tx_abort === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL gmii_unexpected: got %03h expected nothing", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL gmii_byte: got %03h expected %03h", got, e);
                end
            end
        end
        if (tx_en === 1'b1) begin
            if (!prev_en && hi_seen) lo_runs.push_back(lo_cnt);
            hi_cnt = prev_en ? hi_cnt + 1 : 1;
        end else begin
            if (prev_en) begin
                hi_runs.push_back(hi_cnt);
                hi_seen = 1'b1;
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
        end
        prev_en = (tx_en === 1'b1);
    end

    // Reference model: wire image of a frame as the format defines it.
    task automatic push_header(input logic arp, input logic [47:0] d, input logic [47:0] s);
        for (int i = 0; i < 7; i++) exp_q.push_back({3'b100, 8'h55});
        exp_q.push_back({3'b100, 8'hD5});
        for (int i = 0; i < 6; i++) exp_q.push_back({3'b100, d[47 - 8*i -: 8]});
        for (int i = 0; i < 6; i++) exp_q.push_back({3'b100, s[47 - 8*i -: 8]});
        exp_q.push_back({3'b100, 8'h08});
        exp_q.push_back({3'b100, arp ? 8'h06 : 8'h00});
    endtask

    task automatic push_frame(input logic arp, input logic [47:0] d, input logic [47:0] s,
                              input int n, input bit err);
        push_header(arp, d, s);
        for (int i = 0; i < n; i++) exp_q.push_back({3'b100, pl_q[i]});
        if (err) exp_q.push_back(11'h700);
`ifdef ETH_TX_PAD_EN
        else begin
            for (int i = n; i < MIN_PL; i++) exp_q.push_back({3'b100, 8'h00});
        end
`endif
    endtask

    function automatic int frame_len(input int n, input bit err);
        int len;
        len = 22 + n + (err ? 1 : 0);
`ifdef ETH_TX_PAD_EN
        if (!err && n < MIN_PL) len = 22 + MIN_PL;
`endif
        return len;
    endfunction

    task automatic fill_payload(input int n);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
    endtask

    task automatic scramble_inputs();
        arp_in = 1'($urandom);
        d_in   = {16'($urandom), $urandom};
        s_in   = {16'($urandom), $urandom};
    endtask

    // Pulse tx_start from IDLE and check the first preamble byte next cycle.
    task automatic issue_start(input logic arp, input logic [47:0] d, input logic [47:0] s);
        @(negedge clk);
        arp_in = arp; d_in = d; s_in = s;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_latency", {tx_en, txd, tx_busy}, {1'b1, 8'h55, 1'b1});
        @(negedge clk);
        tx_start = 1'b0;
        scramble_inputs();
    endtask

    // Offer n_valid bytes back to back; nr = first index seen with ready low.
    task automatic send_payload(input int n_valid, input bit with_last, input int start_idx,
                                output int nr);
        int w;
        nr = -1;
        w = 0;
        while (!payload_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", int'(payload_ready), 1);
        for (int i = 0; i < n_valid; i++) begin
            if (i > 0) @(negedge clk);
            pvalid   = 1'b1;
            pdata    = pl_q[i];
            plast    = with_last && (i == n_valid - 1);
            tx_start = (i == start_idx);
            if (!payload_ready && nr < 0) nr = i;
            @(posedge clk);
        end
        @(negedge clk);
        pvalid = 1'b0; plast = 1'b0; tx_start = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (tx_busy && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("idle_reached", int'(tx_busy), 0);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic do_frame(input logic arp, input logic [47:0] d, input logic [47:0] s,
                            input int n, input int start_idx);
        int nr;
        push_frame(arp, d, s, n, 1'b0);
        issue_start(arp, d, s);
        send_payload(n, 1'b1, start_idx, nr);
        chk("ready_held", nr, -1);
        wait_idle();
        chk("tx_en_length", hi_runs[$], frame_len(n, 1'b0));
        $display("frame arp=%0b payload=%0d tx_en_cycles=%0d", arp, n, hi_runs[$]);
    endtask

    initial begin
        int nr, n0;
        logic [47:0] db, sb;
        logic        ab;
        rstn = 1'b0; tx_start = 1'b0; arp_in = 1'b0; d_in = '0; s_in = '0;
        pdata = 8'h00; pvalid = 1'b0; plast = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {txd, tx_en, tx_er, payload_ready, tx_busy, tx_abort}, 0);
        @(negedge clk);
        rstn = 1'b1;

        // ARP broadcast, 46-byte payload.
        fill_payload(46);
        do_frame(1'b1, 48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 46, -1);

        // IPv4 with a 4-byte payload.
        pl_q.delete();
        pl_q.push_back(8'hDE); pl_q.push_back(8'hAD);
        pl_q.push_back(8'hBE); pl_q.push_back(8'hEF);
        do_frame(1'b0, 48'h0011_2233_4455, 48'h6677_8899_AABB, 4, -1);

        // Random frames.
        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(1, 60);
            fill_payload(n);
            do_frame(1'($urandom), {16'($urandom), $urandom}, {16'($urandom), $urandom}, n, -1);
        end

        // Underrun after 10 bytes.
        fill_payload(10);
        push_frame(1'b0, 48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 10, 1'b1);
        issue_start(1'b0, 48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F);
        send_payload(10, 1'b0, -1, nr);
        @(posedge clk);
        #1;
        chk("underrun_error", {tx_en, tx_er, tx_abort, txd}, {3'b111, 8'h00});
        for (int i = 1; i <= IFG; i++) begin
            @(posedge clk);
            #1;
            chk("underrun_ifg", {tx_en, tx_abort, tx_busy}, {2'b00, (i < IFG) ? 1'b1 : 1'b0});
        end
        wait_idle();
        chk("underrun_length", hi_runs[$], frame_len(10, 1'b1));
        $display("frame underrun tx_en_cycles=%0d", hi_runs[$]);

        // Oversize: 1501 bytes offered without payload_last.
        fill_payload(1501);
        push_frame(1'b1, 48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 1500, 1'b1);
        issue_start(1'b1, 48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6);
        send_payload(1501, 1'b0, -1, nr);
        chk("oversize_ready_low", nr, 1500);
        wait_idle();
        chk("oversize_length", hi_runs[$], frame_len(1500, 1'b1));
        $display("frame oversize tx_en_cycles=%0d", hi_runs[$]);

        // Reset during MAC_SOURCE, then a clean frame.
        push_header(1'b1, 48'hC0C1_C2C3_C4C5, 48'hD0D1_D2D3_D4D5);
        repeat (5) void'(exp_q.pop_back());
        issue_start(1'b1, 48'hC0C1_C2C3_C4C5, 48'hD0D1_D2D3_D4D5);
        repeat (16) @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_midframe", {txd, tx_en, tx_er, payload_ready, tx_busy, tx_abort}, 0);
        chk("reset_partial_bytes", exp_q.size(), 0);
        @(negedge clk);
        rstn = 1'b1;
        $display("frame reset mid MAC_SOURCE");
        fill_payload(30);
        do_frame(1'b0, {16'($urandom), $urandom}, {16'($urandom), $urandom}, 30, -1);

        // tx_start during PAYLOAD and during IFG is ignored.
        n0 = hi_runs.size();
        fill_payload(50);
        push_frame(1'b1, 48'h1111_2222_3333, 48'h4444_5555_6666, 50, 1'b0);
        issue_start(1'b1, 48'h1111_2222_3333, 48'h4444_5555_6666);
        send_payload(50, 1'b1, 3, nr);
        repeat (3) @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle();
        repeat (30) @(negedge clk);
        chk("ignored_starts_one_frame", hi_runs.size() - n0, 1);
        chk("ignored_starts_idle", int'(tx_busy), 0);
        $display("frame with ignored starts frames=%0d", hi_runs.size() - n0);

        // Back-to-back: tx_start held high through the gap.
        fill_payload(20);
        push_frame(1'b0, 48'h2020_2020_2020, 48'h3030_3030_3030, 20, 1'b0);
        issue_start(1'b0, 48'h2020_2020_2020, 48'h3030_3030_3030);
        send_payload(20, 1'b1, -1, nr);
        ab = 1'b1; db = {16'($urandom), $urandom}; sb = {16'($urandom), $urandom};
        fill_payload(12);
        push_frame(ab, db, sb, 12, 1'b0);
        arp_in = ab; d_in = db; s_in = sb;
        tx_start = 1'b1;
        begin
            int w;
            w = 0;
            while (tx_busy && w < 60) begin
                @(negedge clk);
                w++;
            end
        end
        @(negedge clk);
        tx_start = 1'b0;
        chk("b2b_start", {tx_en, txd}, {1'b1, 8'h55});
        scramble_inputs();
        send_payload(12, 1'b1, -1, nr);
        wait_idle();
        chk("b2b_ifg_gap", lo_runs[$], IFG);
        chk("b2b_length", hi_runs[$], frame_len(12, 1'b0));
        $display("frame back-to-back gap=%0d tx_en_cycles=%0d", lo_runs[$], hi_runs[$]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
